// File: rtl/icap_pkg.sv
// ---------------------------------------------------------------------------
// icap_pkg
// Shared definitions for the ICAPE2 sequencers (the readback reader and the
// multiboot writer):
//   - ICAP command / framing words
//   - configuration register addresses
//   - type-1 read header builder
//   - reader FSM state enum
// ---------------------------------------------------------------------------
package icap_pkg;

  // Framing and command words, in natural bit order.
  localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOP        = 32'h2000_0000;
  localparam logic [31:0] ICAP_CMD_WR_HDR = 32'h3000_8001; // type-1 write, CMD reg, 1 word
  localparam logic [31:0] ICAP_CMD_DESYNC = 32'h0000_000D;

  // Configuration register addresses.
  localparam logic [4:0] REG_STAT    = 5'h07;
  localparam logic [4:0] REG_CMD     = 5'h04;
  localparam logic [4:0] REG_IDCODE  = 5'h0C;
  localparam logic [4:0] REG_WBSTAR  = 5'h10;
  localparam logic [4:0] REG_BOOTSTS = 5'h16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HEAD,
    ST_TURN_RD,
    ST_READ,
    ST_TURN_WR,
    ST_WR_TAIL,
    ST_FIN
  } icap_state_e;

  // Type-1 packet, read opcode, word count 1, register address in [17:13].
  function automatic logic [31:0] type1_rd_hdr(input logic [4:0] addr);
    return 32'h2800_0001 | {14'd0, addr, 13'd0};
  endfunction

endpackage

// File: rtl/icap_reader.sv
// ---------------------------------------------------------------------------
// icap_reader
// Sequencer that reads one 32-bit configuration register through ICAPE2:
// dummy/sync/NOP, type-1 read header, bus turnaround, capture, DESYNC.
// The ICAPE2 primitive and its bit swapping live in a separate port module
// instantiated by the parent; this block only sees natural-order words.
//
// Parameters:
//   RD_LAT  ICAP cycles from the first read-enabled cycle until icap_rdata
//           is valid.
// Ports:
//   clk, rst            ICAP clock, synchronous active-high reset
//   start, reg_addr     one-cycle request and register address (IDLE only)
//   busy, done, rdata   status, completion pulse, captured word
//   icap_cs, icap_rd    chip select (active high), 1 = read direction
//   icap_wdata          word to ICAP
//   icap_rdata          word from ICAP
//   boot_status(_valid) automatically read BOOTSTS value and its flag
// Build option:
//   ICAP_READER_BOOTSTS_EN  when defined, BOOTSTS is read once after every
//                           reset without a start request.
// ---------------------------------------------------------------------------
module icap_reader
  import icap_pkg::*;
#(
  parameter int RD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  reg_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        icap_cs,
  output logic        icap_rd,
  output logic [31:0] icap_wdata,
  input  logic [31:0] icap_rdata,
  output logic [31:0] boot_status,
  output logic        boot_status_valid
);

`ifdef ICAP_READER_BOOTSTS_EN
  localparam logic AUTO_EN = 1'b1;
`else
  localparam logic AUTO_EN = 1'b0;
`endif

  localparam logic [7:0] RD_LAST = 8'(RD_LAT);

  icap_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;       // word / cycle index within a state
  logic [4:0]  addr_q, addr_d;
  logic        auto_q, auto_d;     // current transaction is the BOOTSTS auto-read
  logic        pend_q, pend_d;     // auto-read still owed since reset
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] bs_q, bs_d;
  logic        bsv_q, bsv_d;

  // Next-state logic. State/count registers describe the current cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    addr_d  = addr_q;
    auto_d  = auto_q;
    pend_d  = pend_q;
    rdata_d = rdata_q;
    bs_d    = bs_q;
    bsv_d   = bsv_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (pend_q) begin
          state_d = ST_WR_HEAD;
          addr_d  = REG_BOOTSTS;
          auto_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (start) begin
          state_d = ST_WR_HEAD;
          addr_d  = reg_addr;
          auto_d  = 1'b0;
        end
      end
      ST_WR_HEAD: begin
        if (cnt_q == 8'd5) begin
          state_d = ST_TURN_RD;
          cnt_d   = 8'd0;
        end
      end
      ST_TURN_RD: begin
        state_d = ST_READ;
        cnt_d   = 8'd0;
      end
      ST_READ: begin
        // Last read cycle: icap_rdata is valid RD_LAT cycles after the first.
        if (cnt_q == RD_LAST) begin
          state_d = ST_TURN_WR;
          cnt_d   = 8'd0;
          if (auto_q) bs_d = icap_rdata;
          else        rdata_d = icap_rdata;
        end
      end
      ST_TURN_WR: begin
        state_d = ST_WR_TAIL;
        cnt_d   = 8'd0;
      end
      ST_WR_TAIL: begin
        if (cnt_q == 8'd3) begin
          state_d = ST_FIN;
          cnt_d   = 8'd0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register
  // aligned with the state it describes.
  always_comb begin
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wdata_d = ICAP_DUMMY;
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d  = (state_d == ST_FIN) && !auto_d;

    unique case (state_d)
      ST_WR_HEAD: begin
        cs_d = (cnt_d != 8'd0);
        unique case (cnt_d)
          8'd0:    wdata_d = ICAP_DUMMY;
          8'd1:    wdata_d = ICAP_SYNC;
          8'd3:    wdata_d = type1_rd_hdr(addr_d);
          default: wdata_d = ICAP_NOP;
        endcase
      end
      ST_TURN_RD: begin
        rd_d    = 1'b1;
        wdata_d = ICAP_NOP;
      end
      ST_READ: begin
        cs_d    = 1'b1;
        rd_d    = 1'b1;
        wdata_d = ICAP_NOP;
      end
      ST_TURN_WR: begin
        wdata_d = ICAP_NOP;
      end
      ST_WR_TAIL: begin
        cs_d = 1'b1;
        unique case (cnt_d)
          8'd0:    wdata_d = ICAP_CMD_WR_HDR;
          8'd1:    wdata_d = ICAP_CMD_DESYNC;
          default: wdata_d = ICAP_NOP;
        endcase
      end
      default: begin
        cs_d    = 1'b0;
        rd_d    = 1'b0;
        wdata_d = ICAP_DUMMY;
      end
    endcase
  end

  // The sticky valid flag is set on entry to FIN of the auto-read.
  logic bsv_set;
  assign bsv_set = (state_d == ST_FIN) && auto_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 5'd0;
      auto_q  <= 1'b0;
      pend_q  <= AUTO_EN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= ICAP_DUMMY;
      bs_q    <= 32'd0;
      bsv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      auto_q  <= auto_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      bs_q    <= bs_d;
      bsv_q   <= bsv_d | bsv_set;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign rdata             = rdata_q;
  assign icap_cs           = cs_q;
  assign icap_rd           = rd_q;
  assign icap_wdata        = wdata_q;
  assign boot_status       = bs_q;
  assign boot_status_valid = bsv_q;

endmodule

// File: tb/tb_icap_reader.sv
// ---------------------------------------------------------------------------
// tb_icap_reader
// Two readers (RD_LAT 3 and 5) each talk to a behavioural ICAP model that
// decodes the read header from the write stream, returns garbage until the
// read latency has elapsed and the register value afterwards. Expected bus
// traffic is built per transaction as a list of words from the protocol.
// Honours ICAP_READER_BOOTSTS_EN for the auto-read expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icap_reader;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       start_v;
  logic [1:0][4:0]  addr_v;
  logic [1:0]       busy_v, done_v, cs_v, rd_v, bsv_v;
  logic [1:0][31:0] rdata_v, wdata_v, icrd_v, bs_v;

  int lat [2] = '{3, 5};
  int total = 0;
  int bad   = 0;

  logic [31:0] regval [2][32];

  always #5 clk = ~clk;

  icap_reader #(.RD_LAT(3)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .reg_addr(addr_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]),
    .icap_cs(cs_v[0]), .icap_rd(rd_v[0]), .icap_wdata(wdata_v[0]),
    .icap_rdata(icrd_v[0]), .boot_status(bs_v[0]), .boot_status_valid(bsv_v[0])
  );

  icap_reader #(.RD_LAT(5)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .reg_addr(addr_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]),
    .icap_cs(cs_v[1]), .icap_rd(rd_v[1]), .icap_wdata(wdata_v[1]),
    .icap_rdata(icrd_v[1]), .boot_status(bs_v[1]), .boot_status_valid(bsv_v[1])
  );

  // ICAP model: remembers the address of the last type-1 read header and
  // counts consecutive read-enabled cycles.
  int unsigned rk [2] = '{0, 0};
  logic [4:0]  maddr [2] = '{5'd0, 5'd0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs_v[d] && !rd_v[d] && (wdata_v[d][31:27] == 5'b00101))
        maddr[d] = wdata_v[d][17:13];
      if (cs_v[d] && rd_v[d]) begin
        if (rk[d] >= lat[d]) icrd_v[d] = regval[d][maddr[d]];
        else                 icrd_v[d] = regval[d][maddr[d]] ^ ($urandom | 32'd1);
        rk[d]++;
      end else begin
        rk[d] = 0;
        icrd_v[d] = $urandom;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        cs, rd, busy, done;
    logic [31:0] w;
    bit          wchk;
  } exp_t;
  exp_t q[$];

  function automatic void push(logic cs, logic rd, logic busy, logic done,
                               logic [31:0] w, bit wchk);
    exp_t e;
    e.cs = cs; e.rd = rd; e.busy = busy; e.done = done; e.w = w; e.wchk = wchk;
    q.push_back(e);
  endfunction

  // Checks the 20 cycles following a reset release.
  task automatic after_reset();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
`ifdef ICAP_READER_BOOTSTS_EN
        check("auto_bsv", 64'(bsv_v[d]), 64'(c >= 14 + lat[d]));
        check("auto_done", 64'(done_v[d]), 64'd0);
        check("auto_busy", 64'(busy_v[d]), 64'(c <= 13 + lat[d]));
        if (c >= 14 + lat[d]) check("auto_bs", 64'(bs_v[d]), 64'(regval[d][22]));
        if (c == 20) check("auto_rdata", 64'(rdata_v[d]), 64'd0);
`else
        check("idle_ctl", 64'({busy_v[d], done_v[d], cs_v[d], rd_v[d], bsv_v[d]}), 64'd0);
        check("idle_w", 64'(wdata_v[d]), 64'hFFFF_FFFF);
        check("idle_bs", 64'(bs_v[d]), 64'd0);
`endif
      end
    end
  endtask

  // One read on reader d. abort_at: cycle at which rst is raised (0 = none).
  // extra: also pulse start at cycle 5 and in the done cycle.
  task automatic run_txn(input int d, input logic [4:0] a, input int abort_at, input bit extra);
    int L;
    logic [31:0] expv;
    exp_t e;
    L = lat[d];
    expv = regval[d][a];
    q.delete();
    push(0, 0, 1, 0, 32'hFFFF_FFFF, 1);
    push(1, 0, 1, 0, 32'hAA99_5566, 1);
    push(1, 0, 1, 0, 32'h2000_0000, 1);
    push(1, 0, 1, 0, 32'h2800_0001 | (32'(a) << 13), 1);
    push(1, 0, 1, 0, 32'h2000_0000, 1);
    push(1, 0, 1, 0, 32'h2000_0000, 1);
    push(0, 1, 1, 0, 32'h2000_0000, 1);
    for (int i = 0; i <= L; i++) push(1, 1, 1, 0, 32'd0, 0);
    push(0, 0, 1, 0, 32'd0, 0);
    push(1, 0, 1, 0, 32'h3000_8001, 1);
    push(1, 0, 1, 0, 32'h0000_000D, 1);
    push(1, 0, 1, 0, 32'h2000_0000, 1);
    push(1, 0, 1, 0, 32'h2000_0000, 1);
    push(0, 0, 0, 1, 32'd0, 0);

    @(negedge clk);
    start_v[d] = 1'b1;
    addr_v[d]  = a;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    addr_v[d]  = 5'($urandom);
    for (int c = 1; c <= q.size(); c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e = q[c-1];
      check($sformatf("ctl_c%0d", c), 64'({cs_v[d], rd_v[d], busy_v[d], done_v[d]}),
            64'({e.cs, e.rd, e.busy, e.done}));
      if (e.wchk) check($sformatf("wdata_c%0d", c), 64'(wdata_v[d]), 64'(e.w));
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ctl", 64'({cs_v[d], rd_v[d], busy_v[d], done_v[d]}), 64'd0);
        check("abort_w", 64'(wdata_v[d]), 64'hFFFF_FFFF);
        rst = 1'b0;
        $display("txn dut=%0d addr=%h aborted at cycle %0d", d, a, c);
        after_reset();
        return;
      end
      if (extra && c == 5) begin start_v[d] = 1'b1; addr_v[d] = 5'($urandom); end
      if (extra && c == 6) start_v[d] = 1'b0;
      if (c == q.size()) begin
        check("rdata", 64'(rdata_v[d]), 64'(expv));
        if (extra) start_v[d] = 1'b1;
      end
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    check("post_idle", 64'({busy_v[d], done_v[d], cs_v[d]}), 64'd0);
    check("rdata_hold", 64'(rdata_v[d]), 64'(expv));
    $display("txn dut=%0d lat=%0d addr=%h rdata=%h exp=%h", d, L, a, rdata_v[d], expv);
  endtask

  initial begin
    logic [4:0] addrs [5];
    int d;
    logic [4:0] a;
    addrs = '{5'h07, 5'h0C, 5'h10, 5'h16, 5'h00};
    rst = 1'b1;
    start_v = '0;
    addr_v = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 32; j++) regval[i][j] = $urandom;
    regval[0][22] = 32'h0000_0005;
    regval[1][22] = 32'h0000_0005;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    after_reset();

    regval[0][22] = 32'h0000_0001;
    run_txn(0, 5'h16, 0, 0);
    regval[0][16] = 32'h0001_0000;
    run_txn(0, 5'h10, 0, 1);
    run_txn(0, 5'h16, 9, 0);
    regval[0][12] = 32'h0362_D093;
    run_txn(0, 5'h0C, 0, 0);
    run_txn(1, 5'h16, 0, 0);
    run_txn(1, 5'h10, 0, 1);

    for (int n = 0; n < 10; n++) begin
      d = int'($urandom_range(0, 1));
      a = addrs[$urandom_range(0, 4)];
      if (a == 5'h00) a = 5'($urandom);
      regval[d][a] = $urandom;
      run_txn(d, a, 0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
